// File: rtl/cordic_polar_post.sv
// Post-processing stage for the vectoring CORDIC: removes the CORDIC gain, derives the quadrant
// and buffers results in a show-ahead FIFO with credit-based input backpressure.
module cordic_polar_post #(
  parameter int DATA_WIDTH = 15,
  parameter int KINV       = 19899,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_mag,
  input  logic [DATA_WIDTH-1:0] in_theta,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_mag,
  output logic [DATA_WIDTH-1:0] out_theta,
  output logic [1:0]            out_quad,
  output logic [CNT_WIDTH-1:0]  out_count
);
  localparam int PW = 2 * DATA_WIDTH;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [PW-1:0] KINV_P = PW'(KINV);

  logic                  s1_valid_q, s1_valid_d;
  logic [DATA_WIDTH-1:0] s1_mag_q, s1_mag_d;
  logic [DATA_WIDTH-1:0] s1_theta_q, s1_theta_d;
  logic                  s2_valid_q, s2_valid_d;
  logic [PW-1:0]         s2_prod_q, s2_prod_d;
  logic [DATA_WIDTH-1:0] s2_theta_q, s2_theta_d;
  logic [DATA_WIDTH-1:0] mag_mem_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] mag_mem_d [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] theta_mem_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] theta_mem_d [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         fcount_q, fcount_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_mag_q, out_mag_d;
  logic [DATA_WIDTH-1:0] out_theta_q, out_theta_d;
  logic [1:0]            out_quad_q, out_quad_d;
  logic [CNT_WIDTH-1:0]  out_count_q, out_count_d;
  logic                  in_ready_q, in_ready_d;

  logic                  accept_s;
  logic                  push_s;
  logic                  pop_s;
  logic [DATA_WIDTH-1:0] push_mag_s;
  logic [CW:0]           credit_s;

  // Next-state logic for pipeline, FIFO, registered head and credit
  always_comb begin
    accept_s   = in_valid & in_ready_q;
    push_s     = s2_valid_q;
    pop_s      = out_valid_q & out_ready;
    push_mag_s = s2_prod_q[PW-1:DATA_WIDTH];

    s1_valid_d = accept_s;
    s1_mag_d   = accept_s ? in_mag : s1_mag_q;
    s1_theta_d = accept_s ? in_theta : s1_theta_q;
    s2_valid_d = s1_valid_q;
    s2_prod_d  = PW'(s1_mag_q) * KINV_P;
    s2_theta_d = s1_theta_q;

    mag_mem_d   = mag_mem_q;
    theta_mem_d = theta_mem_q;
    if (push_s) begin
      mag_mem_d[wr_ptr_q]   = push_mag_s;
      theta_mem_d[wr_ptr_q] = s2_theta_q;
    end else begin
      mag_mem_d   = mag_mem_q;
      theta_mem_d = theta_mem_q;
    end
    wr_ptr_d = push_s ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop_s ? rd_ptr_q + AW'(1) : rd_ptr_q;

    case ({push_s, pop_s})
      2'b10:   fcount_d = fcount_q + CW'(1);
      2'b01:   fcount_d = fcount_q - CW'(1);
      default: fcount_d = fcount_q;
    endcase

    // Head is registered; a lone entry written this cycle bypasses the memory
    out_valid_d = (fcount_d != CW'(0));
    if (fcount_d == CW'(0)) begin
      out_mag_d   = out_mag_q;
      out_theta_d = out_theta_q;
    end else if (push_s && (fcount_d == CW'(1))) begin
      out_mag_d   = push_mag_s;
      out_theta_d = s2_theta_q;
    end else begin
      out_mag_d   = mag_mem_q[rd_ptr_d];
      out_theta_d = theta_mem_q[rd_ptr_d];
    end
    out_quad_d  = out_theta_d[DATA_WIDTH-1 -: 2];
    out_count_d = pop_s ? out_count_q + CNT_WIDTH'(1) : out_count_q;

    credit_s   = (CW+1)'(fcount_d) + (CW+1)'(s1_valid_d) + (CW+1)'(s2_valid_d);
    in_ready_d = (credit_s < (CW+1)'(FIFO_DEPTH));
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_mag_q    <= '0;
      s1_theta_q  <= '0;
      s2_valid_q  <= 1'b0;
      s2_prod_q   <= '0;
      s2_theta_q  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mag_mem_q[i]   <= '0;
        theta_mem_q[i] <= '0;
      end
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fcount_q    <= '0;
      out_valid_q <= 1'b0;
      out_mag_q   <= '0;
      out_theta_q <= '0;
      out_quad_q  <= 2'b00;
      out_count_q <= '0;
      in_ready_q  <= 1'b1;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_mag_q    <= s1_mag_d;
      s1_theta_q  <= s1_theta_d;
      s2_valid_q  <= s2_valid_d;
      s2_prod_q   <= s2_prod_d;
      s2_theta_q  <= s2_theta_d;
      mag_mem_q   <= mag_mem_d;
      theta_mem_q <= theta_mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fcount_q    <= fcount_d;
      out_valid_q <= out_valid_d;
      out_mag_q   <= out_mag_d;
      out_theta_q <= out_theta_d;
      out_quad_q  <= out_quad_d;
      out_count_q <= out_count_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_mag   = out_mag_q;
  assign out_theta = out_theta_q;
  assign out_quad  = out_quad_q;
  assign out_count = out_count_q;

endmodule

// File: tb/tb_cordic_polar_post.sv
// Directed bench for cordic_polar_post: queue-based reference model checked every cycle,
// plus hand-computed expectations at key points of each scenario.
module tb_cordic_polar_post;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [14:0] in_mag;
  logic [14:0] in_theta;
  logic        out_valid;
  logic        out_ready;
  logic [14:0] out_mag;
  logic [14:0] out_theta;
  logic [1:0]  out_quad;
  logic [15:0] out_count;

  always #5 clk = ~clk;

  cordic_polar_post dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_mag(in_mag), .in_theta(in_theta),
    .out_valid(out_valid), .out_ready(out_ready), .out_mag(out_mag), .out_theta(out_theta),
    .out_quad(out_quad), .out_count(out_count)
  );

  typedef struct {
    int due;
    int mag;
    int theta;
  } ent_t;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  ent_t pipe_q[$];
  ent_t fifo_q[$];
  int   m_count = 0;
  bit   m_in_ready = 1'b1;
  int   m_head_mag = 0;
  int   m_head_theta = 0;
  int   seen_ready;

  function automatic int mag_model(input int m);
    return (m * 19899) / 32768;
  endfunction

  function automatic int quad_model(input int th);
    if (th >= 8192) return 1;
    else if (th >= 0) return 0;
    else if (th >= -8192) return 3;
    else return 2;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit   acc;
    ent_t e;
    cyc++;
    if (rst) begin
      pipe_q.delete();
      fifo_q.delete();
      m_count = 0;
      m_in_ready = 1'b1;
      m_head_mag = 0;
      m_head_theta = 0;
    end else begin
      acc = in_valid && m_in_ready;
      if (fifo_q.size() > 0 && out_ready) begin
        void'(fifo_q.pop_front());
        m_count = (m_count + 1) % 65536;
      end
      while (pipe_q.size() > 0 && pipe_q[0].due == cyc) fifo_q.push_back(pipe_q.pop_front());
      if (acc) begin
        e.due = cyc + 2;
        e.mag = mag_model(int'(in_mag));
        e.theta = int'($signed(in_theta));
        pipe_q.push_back(e);
      end
      m_in_ready = (fifo_q.size() + pipe_q.size()) < 4;
      if (fifo_q.size() > 0) begin
        m_head_mag = fifo_q[0].mag;
        m_head_theta = fifo_q[0].theta;
      end
    end
  endtask

  task automatic compare();
    logic [14:0] th;
    th = 15'(m_head_theta);
    chk("in_ready", {31'd0, in_ready}, {31'd0, m_in_ready});
    chk("out_valid", {31'd0, out_valid}, (fifo_q.size() > 0) ? 32'd1 : 32'd0);
    chk("out_count", {16'd0, out_count}, 32'(m_count));
    chk("out_mag", {17'd0, out_mag}, 32'(m_head_mag));
    chk("out_theta", {17'd0, out_theta}, {17'd0, th});
    chk("out_quad", {30'd0, out_quad}, 32'(quad_model(m_head_theta)));
  endtask

  // One clock: model follows the active edge, DUT is compared on the falling edge
  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare();
  endtask

  int th_tab[4] = '{8192, -16384, -8192, 16383};
  int q_tab[4]  = '{1, 2, 3, 1};

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_mag = 15'd0; in_theta = 15'd0;

    // Model sanity against hand-computed values
    chk("model_mag_6744", 32'(mag_model(6744)), 32'd4095);
    chk("model_mag_max", 32'(mag_model(32767)), 32'd19898);
    chk("model_quad_neg", 32'(quad_model(-8192)), 32'd3);

    // 1: reset
    for (int i = 0; i < 20; i++) cycle();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_count", {16'd0, out_count}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_mag", {17'd0, out_mag}, 32'd0);
    rst = 1'b0;

    // 2: single sample
    out_ready = 1'b1; in_valid = 1'b1; in_mag = 15'd6744; in_theta = 15'd685;
    cycle();
    in_valid = 1'b0;
    cycle();
    chk("single_not_yet", {31'd0, out_valid}, 32'd0);
    cycle();
    chk("single_valid", {31'd0, out_valid}, 32'd1);
    chk("single_mag", {17'd0, out_mag}, 32'd4095);
    chk("single_theta", {17'd0, out_theta}, 32'd685);
    chk("single_quad", {30'd0, out_quad}, 32'd0);
    cycle();
    chk("single_count", {16'd0, out_count}, 32'd1);

    // 3: quadrants at full-scale magnitude
    for (int k = 0; k < 6; k++) begin
      if (k < 4) begin
        in_valid = 1'b1; in_mag = 15'd32767; in_theta = 15'(th_tab[k]);
      end else begin
        in_valid = 1'b0;
      end
      cycle();
      if (k >= 2) begin
        chk("quad_value", {30'd0, out_quad}, 32'(q_tab[k-2]));
        chk("quad_mag", {17'd0, out_mag}, 32'd19898);
      end
    end
    cycle();

    // 4: backpressure
    out_ready = 1'b0; seen_ready = 0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_mag = 15'(1000 * (i + 1)); in_theta = 15'(i * 3000 - 9000);
      if (in_ready) seen_ready++;
      cycle();
    end
    in_valid = 1'b0;
    chk("bp_accepted", 32'(seen_ready), 32'd4);
    chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
    chk("bp_head_mag", {17'd0, out_mag}, 32'd607);
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) cycle();
    chk("bp_in_ready_back", {31'd0, in_ready}, 32'd1);
    chk("bp_count", {16'd0, out_count}, 32'd9);

    // 5: fill, then simultaneous push/pop streaming
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_mag = 15'(500 * i + 7); in_theta = 15'(i * 1500 - 16000);
      cycle();
    end
    out_ready = 1'b1; seen_ready = 0;
    for (int i = 6; i < 22; i++) begin
      in_valid = 1'b1; in_mag = 15'(500 * i + 7); in_theta = 15'(i * 1500 - 16000);
      if (in_ready) seen_ready++;
      cycle();
    end
    in_valid = 1'b0;
    chk("tp_accepted", 32'(seen_ready), 32'd15);
    chk("tp_count", {16'd0, out_count}, 32'd25);
    chk("tp_valid", {31'd0, out_valid}, 32'd1);
    for (int i = 0; i < 6; i++) cycle();
    chk("tp_drain_count", {16'd0, out_count}, 32'd28);
    chk("tp_drain_valid", {31'd0, out_valid}, 32'd0);

    // 6: reset with data in FIFO and pipeline
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_mag = 15'(3000 + i); in_theta = 15'(100 * i);
      cycle();
    end
    rst = 1'b1;
    cycle();
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_ready", {31'd0, in_ready}, 32'd1);
    chk("mid_rst_count", {16'd0, out_count}, 32'd0);
    chk("mid_rst_mag", {17'd0, out_mag}, 32'd0);
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) cycle();
    chk("post_rst_empty", {31'd0, out_valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
